// File: rtl/result_sram_drain.sv
// result_sram_drain: streams a rows x cols result matrix out of the result
// SRAM in row-major order onto a valid/ready beat interface.
// Reads are throttled so that a 2-entry output FIFO can never overflow.
// The SRAM has 1-cycle read latency.
// Optional feature: define RESULT_DRAIN_ROW_LAST_EN to add m_row_last, which
// marks the beat in the final column of each row.
module result_sram_drain #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [15:0]       cfg_rows,
    input  logic [15:0]       cfg_cols,
    output logic [ADDR_W-1:0] sram_result_read_address,
    input  logic [DATA_W-1:0] tb_sram_result_read_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
`ifdef RESULT_DRAIN_ROW_LAST_EN
    output logic              m_row_last,
`endif
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q;
    logic              start_ready_q, done_q, err_q;
    logic [31:0]       total_q, rd_cnt_q;
    logic [ADDR_W-1:0] rd_addr_q, last_addr_q;
    logic              ret_q, ret_last_q;

    logic [DATA_W-1:0] fifo_data_q [2];
    logic [1:0]        fifo_last_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        occ_q;

    logic [31:0]       total_w;
    logic              range_bad, handshake, pop, issue, last_issue;

    assign total_w   = 32'(cfg_rows) * 32'(cfg_cols);
    // Last element address must fit in the SRAM: BASE + total - 1 <= 2^ADDR_W - 1.
    assign range_bad = (total_w != 32'd0) &&
                       (({32'd0, total_w} + 64'(BASE_ADDR)) > (64'd1 << ADDR_W));
    assign handshake = start_valid && start_ready_q;

    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid && m_ready;
    // Credit the beat leaving this cycle so a full-rate sink sees no bubbles;
    // occupancy after this edge plus the new in-flight read never exceeds 2.
    assign issue      = (state_q == RUN) && ((3'(occ_q) + 3'(ret_q)) < (3'd2 + 3'(pop)));
    assign last_issue = issue && (rd_cnt_q == total_q - 32'd1);

    // The bus shows the issuing address, otherwise the last one read.
    assign sram_result_read_address = issue ? rd_addr_q : last_addr_q;

    assign m_data      = fifo_data_q[rd_ptr_q];
    assign m_last      = fifo_last_q[rd_ptr_q] && m_valid;
    assign start_ready = start_ready_q;
    assign done        = done_q;
    assign err         = err_q;

`ifdef RESULT_DRAIN_ROW_LAST_EN
    logic [15:0] cols_q, col_q;
    logic        ret_rl_q;
    logic [1:0]  fifo_rl_q;
    logic        col_end;

    assign col_end    = (col_q == cols_q - 16'd1);
    assign m_row_last = fifo_rl_q[rd_ptr_q] && m_valid;

    // Column position of the next read; flags the last column of every row.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cols_q    <= '0;
            col_q     <= '0;
            ret_rl_q  <= 1'b0;
            fifo_rl_q <= '0;
        end else begin
            if (handshake) begin
                cols_q <= cfg_cols;
                col_q  <= '0;
            end else if (issue) begin
                col_q <= col_end ? 16'd0 : col_q + 16'd1;
            end
            ret_rl_q <= issue && col_end;
            if (ret_q) fifo_rl_q[wr_ptr_q] <= ret_rl_q;
        end
    end
`endif

    // Control FSM plus read sequencing; done/err/start_ready are registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            start_ready_q <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            total_q       <= '0;
            rd_cnt_q      <= '0;
            rd_addr_q     <= ADDR_W'(BASE_ADDR);
            last_addr_q   <= ADDR_W'(BASE_ADDR);
            ret_q         <= 1'b0;
            ret_last_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        total_q       <= total_w;
                        rd_cnt_q      <= '0;
                        rd_addr_q     <= ADDR_W'(BASE_ADDR);
                        err_q         <= range_bad;
                        start_ready_q <= 1'b0;
                        if (total_w == 32'd0 || range_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (last_issue) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q       <= IDLE;
                    start_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (issue) begin
                rd_cnt_q    <= rd_cnt_q + 32'd1;
                rd_addr_q   <= rd_addr_q + 1'b1;
                last_addr_q <= rd_addr_q;
            end
            ret_q      <= issue;
            ret_last_q <= last_issue;
        end
    end

    // 2-entry output FIFO fed by returning SRAM data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= '0;
        end else begin
            if (ret_q) begin
                fifo_data_q[wr_ptr_q] <= tb_sram_result_read_data;
                fifo_last_q[wr_ptr_q] <= ret_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + 2'(ret_q) - 2'(pop);
        end
    end

endmodule
